// File: rtl/multicycle_controller.sv
// Sequencing FSM for the Eka RV32I multi-cycle core (FETCH/DECODE/EXEC/MEM/WB).
// Latency: ALU 4, load 5, store 4, branch 3 cycles with zero-wait acks; +1 per ack wait cycle.
// Backpressure: imem_req/dmem_req held until ack; stall_req parks the core in IDLE at boundaries.
// Optional retire counter enabled by defining EKA_RETIRE_COUNTER_EN.
module multicycle_controller #(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_req,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    input  logic                 dec_write_en,
    input  logic                 dec_mem_read_en,
    input  logic                 dec_mem_write_en,
    input  logic                 dec_branch_inst,
    input  logic                 branch_taken,
    output logic                 imem_req,
    output logic                 ir_load,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 rf_write_strobe,
    output logic                 pc_update,
    output logic                 pc_sel_branch,
    output logic                 busy,
    output logic [2:0]           state_o,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t state;
    logic   lat_we;
    logic   lat_rd;
    logic   lat_wr;
    logic   lat_br;
    logic   exec_retire;

    // Sequencing state and per-instruction class flags captured in DECODE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            lat_we <= 1'b0;
            lat_rd <= 1'b0;
            lat_wr <= 1'b0;
            lat_br <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!stall_req) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) state <= S_DECODE;
                end
                S_DECODE: begin
                    lat_we <= dec_write_en;
                    lat_rd <= dec_mem_read_en;
                    lat_wr <= dec_mem_write_en;
                    lat_br <= dec_branch_inst;
                    state  <= S_EXEC;
                end
                S_EXEC: begin
                    if (lat_rd || lat_wr)  state <= S_MEM;
                    else if (lat_we)       state <= S_WB;
                    else if (stall_req)    state <= S_IDLE;
                    else                   state <= S_FETCH;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        // Load wins when both mem flags are set
                        if (lat_rd)         state <= S_WB;
                        else if (stall_req) state <= S_IDLE;
                        else                state <= S_FETCH;
                    end
                end
                S_WB: begin
                    if (stall_req) state <= S_IDLE;
                    else           state <= S_FETCH;
                end
                // Encodings 6/7 recover to IDLE
                default: state <= S_IDLE;
            endcase
        end
    end

    // Instructions that neither touch memory nor write rd retire directly from EXEC
    assign exec_retire = (state == S_EXEC) && !lat_rd && !lat_wr && !lat_we;

    // Moore decode from the state register; ir_load and store retire are ack-qualified
    always_comb begin
        imem_req        = (state == S_FETCH);
        ir_load         = (state == S_FETCH) && imem_ack;
        dmem_req        = (state == S_MEM);
        dmem_we         = (state == S_MEM) && lat_wr && !lat_rd;
        rf_write_strobe = (state == S_WB);
        pc_update       = (state == S_WB) || exec_retire ||
                          ((state == S_MEM) && dmem_ack && lat_wr && !lat_rd);
        pc_sel_branch   = exec_retire && lat_br && branch_taken;
        busy            = (state != S_IDLE);
    end

    assign state_o = state;

`ifdef EKA_RETIRE_COUNTER_EN
    logic [INSTRET_W-1:0] instret_q;

    // Count retire pulses; wraps naturally at 2^INSTRET_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          instret_q <= '0;
        else if (pc_update) instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instructions, expected retire records queued.
// Stimulus drives at posedge+1, memory responders at posedge+2, monitor samples at negedge.
// Each retire (pc_update) pops one expected record and compares per-instruction observations.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_req;
    logic        imem_ack;
    logic        dmem_ack;
    logic        dec_write_en;
    logic        dec_mem_read_en;
    logic        dec_mem_write_en;
    logic        dec_branch_inst;
    logic        branch_taken;
    logic        imem_req;
    logic        ir_load;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_write_strobe;
    logic        pc_update;
    logic        pc_sel_branch;
    logic        busy;
    logic [2:0]  state_o;
    logic [63:0] instret;

    multicycle_controller #(.INSTRET_W(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_req        (stall_req),
        .imem_ack         (imem_ack),
        .dmem_ack         (dmem_ack),
        .dec_write_en     (dec_write_en),
        .dec_mem_read_en  (dec_mem_read_en),
        .dec_mem_write_en (dec_mem_write_en),
        .dec_branch_inst  (dec_branch_inst),
        .branch_taken     (branch_taken),
        .imem_req         (imem_req),
        .ir_load          (ir_load),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .rf_write_strobe  (rf_write_strobe),
        .pc_update        (pc_update),
        .pc_sel_branch    (pc_sel_branch),
        .busy             (busy),
        .state_o          (state_o),
        .instret          (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lat;
        logic [2:0] st;
        int         rf;
        logic       sel;
        int         dreq;
        int         dwe;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   issued   = 0;
    int   retired  = 0;
    int   imem_wait = 0;
    int   dmem_wait = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory responder: ack after imem_wait cycles of request
    initial begin
        int icnt;
        icnt = 0;
        imem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (imem_req) begin
                imem_ack = (icnt >= imem_wait);
                icnt++;
            end else begin
                imem_ack = 1'b0;
                icnt = 0;
            end
        end
    end

    // Data memory responder: ack after dmem_wait cycles of request
    initial begin
        int dcnt;
        dcnt = 0;
        dmem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (dmem_req) begin
                dmem_ack = (dcnt >= dmem_wait);
                dcnt++;
            end else begin
                dmem_ack = 1'b0;
                dcnt = 0;
            end
        end
    end

    // Monitor: accumulate per-instruction observations, compare on each retire
    initial begin
        int cyc, rf_cnt, dreq_cnt, dwe_cnt, ir_cnt;
        logic [2:0] prev;
        exp_t e;
        logic [63:0] exp_instret;
        cyc = 0; rf_cnt = 0; dreq_cnt = 0; dwe_cnt = 0; ir_cnt = 0; prev = 3'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cyc = 0; rf_cnt = 0; dreq_cnt = 0; dwe_cnt = 0; ir_cnt = 0; prev = 3'd0;
            end else begin
                if (state_o == 3'd1 && prev != 3'd1) begin
                    cyc = 0; rf_cnt = 0; dreq_cnt = 0; dwe_cnt = 0; ir_cnt = 0;
                end
                if (busy) cyc++;
                rf_cnt   += int'(rf_write_strobe);
                dreq_cnt += int'(dmem_req);
                dwe_cnt  += int'(dmem_we);
                ir_cnt   += int'(ir_load);
                if (pc_update) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_retire", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
`ifdef EKA_RETIRE_COUNTER_EN
                        exp_instret = 64'(retired);
`else
                        exp_instret = 64'd0;
`endif
                        chk("retire_state", 64'(state_o), 64'(e.st));
                        chk("latency", 64'(cyc), 64'(e.lat));
                        chk("rf_strobe_count", 64'(rf_cnt), 64'(e.rf));
                        chk("rf_strobe_with_pc", 64'(rf_write_strobe), 64'(e.rf));
                        chk("pc_sel_branch", 64'(pc_sel_branch), 64'(e.sel));
                        chk("dmem_req_cycles", 64'(dreq_cnt), 64'(e.dreq));
                        chk("dmem_we_cycles", 64'(dwe_cnt), 64'(e.dwe));
                        chk("ir_load_count", 64'(ir_cnt), 64'd1);
                        chk("instret", instret, exp_instret);
                    end
                    retired++;
                end
                prev = state_o;
            end
        end
    end

    task automatic wait_retire();
        int k;
        k = 0;
        while (retired < issued && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("retire_wait", 64'(retired), 64'(issued));
    endtask

    // Issue one instruction's decoder flags and its expected retire record
    task automatic run(input logic we, input logic rd, input logic wr, input logic br,
                       input logic tk, input int iw, input int dw,
                       input int lat, input logic [2:0] st, input int rf,
                       input logic sel, input int dreq, input int dwe);
        exp_t e;
        dec_write_en     = we;
        dec_mem_read_en  = rd;
        dec_mem_write_en = wr;
        dec_branch_inst  = br;
        branch_taken     = tk;
        imem_wait        = iw;
        dmem_wait        = dw;
        e.lat = lat; e.st = st; e.rf = rf; e.sel = sel; e.dreq = dreq; e.dwe = dwe;
        exp_q.push_back(e);
        issued++;
        wait_retire();
    endtask

    initial begin
        int k;
        reset = 1'b1;
        stall_req = 1'b0;
        dec_write_en = 1'b1;
        dec_mem_read_en = 1'b0;
        dec_mem_write_en = 1'b0;
        dec_branch_inst = 1'b0;
        branch_taken = 1'b0;
        #2;
        chk("reset_outputs", 64'({imem_req, ir_load, dmem_req, dmem_we, rf_write_strobe,
                                  pc_update, pc_sel_branch, busy}), 64'd0);
        chk("reset_state", 64'(state_o), 64'd0);
        chk("reset_instret", instret, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        //  we  rd  wr  br  tk  iw dw  lat st    rf sel dreq dwe
        run(1, 0, 0, 0, 0, 0, 0, 4, 3'd5, 1, 0, 0, 0);   // ADDI
        run(1, 1, 0, 0, 0, 0, 2, 7, 3'd5, 1, 0, 3, 0);   // load, 2 wait cycles
        run(0, 0, 1, 0, 0, 0, 0, 4, 3'd4, 0, 0, 1, 1);   // store
        run(0, 0, 0, 1, 1, 0, 0, 3, 3'd3, 0, 1, 0, 0);   // branch taken
        run(0, 0, 0, 1, 0, 0, 0, 3, 3'd3, 0, 0, 0, 0);   // branch not taken
        run(1, 0, 0, 0, 0, 2, 0, 6, 3'd5, 1, 0, 0, 0);   // ALU, 2 fetch waits
        run(1, 1, 1, 0, 0, 0, 1, 6, 3'd5, 1, 0, 2, 0);   // both mem flags -> load
        run(0, 0, 0, 0, 1, 0, 0, 3, 3'd3, 0, 0, 0, 0);   // no-op class, taken ignored

        // Stall across the boundary after WB
        stall_req = 1'b1;
        run(1, 0, 0, 0, 0, 0, 0, 4, 3'd5, 1, 0, 0, 0);
        @(negedge clk);
        chk("stall_state", 64'(state_o), 64'd0);
        chk("stall_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("stall_hold", 64'(state_o), 64'd0);
        stall_req = 1'b0;
        dec_write_en = 1'b1; dec_mem_read_en = 1'b0; dec_mem_write_en = 1'b0; dec_branch_inst = 1'b0;
        @(negedge clk);
        chk("stall_release_state", 64'(state_o), 64'd0);
        @(negedge clk);
        chk("stall_release_fetch", 64'(state_o), 64'd1);
        run(1, 0, 0, 0, 0, 0, 0, 4, 3'd5, 1, 0, 0, 0);

        // Reset in the middle of a long MEM wait
        dec_write_en = 1'b1; dec_mem_read_en = 1'b1; dec_mem_write_en = 1'b0; dec_branch_inst = 1'b0;
        dmem_wait = 20;
        k = 0;
        while (!dmem_req && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("reach_mem", 64'(dmem_req), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_dmem_req", 64'(dmem_req), 64'd0);
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_outputs", 64'({imem_req, ir_load, dmem_req, dmem_we, rf_write_strobe,
                                pc_update, pc_sel_branch, busy}), 64'd0);
        chk("rst_instret", instret, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("no_retire_on_reset", 64'(retired), 64'(issued));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
